// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch buffer entries pair each instruction word with its PC.
package ifu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALT
    } ifu_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer of fetch_entry_t.
// Flush has priority over push and pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC sequencing, in-order imem requests, buffering.
// Define IFU_ALIGN_CHECK_EN to halt on misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    ifu_state_t   state;
    ifu_state_t   state_nx;
    logic [31:0]  fetch_pc;
    logic [31:0]  rsp_pc;
    logic [31:0]  redir_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nx;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic         fifo_empty;
    logic         req_ok;
    logic         accept;
    logic         drop;
    logic         push;
    logic         pop;
    logic         misalign;
    fetch_entry_t head;

`ifdef IFU_ALIGN_CHECK_EN
    assign misalign       = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_pc       = redirect_pc;
    assign fetch_misalign = (state == HALT);
`else
    assign misalign       = 1'b0;
    assign redir_pc       = redirect_pc & ~32'h3;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= BOOT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:    state_nx = FETCH;
            FETCH:   state_nx = FETCH;
            HALT:    if (redirect_valid) state_nx = FETCH;
            default: state_nx = BOOT;
        endcase
        if (misalign)
            state_nx = HALT;
    end

    // Buffer slots are reserved at request time, so a response always fits.
    assign req_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_LIM;
    assign imem_req_valid = (state == FETCH) && req_ok;
    assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
    assign accept = imem_req_valid && imem_req_ready;

    assign drop = (discard != '0);
    assign push = imem_rsp_valid && !drop;
    assign pop  = instr_valid && instr_ready;

    assign outstanding_nx = outstanding + CW'(accept) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nx;
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                discard  <= outstanding_nx;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + PC_STEP;
                if (imem_rsp_valid) begin
                    if (drop)
                        discard <= discard - CW'(1);
                    else
                        rsp_pc <= rsp_pc + PC_STEP;
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ('{instr: imem_rsp_data, pc: rsp_pc}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr_data  = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order PC stream model.
// Honours IFU_ALIGN_CHECK_EN the same way as the design.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          first_acc = -1;
    int          first_val = -1;
    bit          halted = 1'b0;
    bit          exp_mis = 1'b0;
    bit          saw_zero = 1'b0;
    logic [31:0] exp_req_pc = RST_PC;
    logic [31:0] exp_out_pc = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef IFU_ALIGN_CHECK_EN
        return p;
`else
        return p & ~32'h3;
`endif
    endfunction

    function automatic bit is_mis(input logic [31:0] p);
`ifdef IFU_ALIGN_CHECK_EN
        return p[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory drives a due response, the model scores the
    // handshakes that the coming edge will complete.
    task automatic tick();
        bit acc;
        bit pp;
        int d;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (!rst_n) begin
            mq.delete();
            last_due   = 0;
            exp_req_pc = RST_PC;
            exp_out_pc = RST_PC;
            halted     = 1'b0;
            exp_mis    = 1'b0;
        end else begin
            chk("misalign", fetch_misalign, exp_mis);
            acc = imem_req_valid && imem_req_ready;
            pp  = instr_valid && instr_ready;
            if (halted) begin
                chk("halt_req", imem_req_valid, 1'b0);
                chk("halt_out", instr_valid, 1'b0);
            end
            if (instr_valid && first_val < 0)
                first_val = cyc;
            if (pp) begin
                chk("instr_pc", instr_pc, exp_out_pc);
                chk("instr_data", instr_data, mem_word(exp_out_pc));
                if (instr_pc == 32'h0)
                    saw_zero = 1'b1;
                n_pop++;
                exp_out_pc += 32'd4;
            end
            if (acc) begin
                chk("req_addr", imem_req_addr, exp_req_pc);
                d = cyc + lat;
                if (d <= last_due)
                    d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: imem_req_addr, due: d});
                n_acc++;
                if (first_acc < 0)
                    first_acc = cyc;
                exp_req_pc += 32'd4;
            end
            if (redirect_valid) begin
                exp_req_pc = tgt(redirect_pc);
                exp_out_pc = tgt(redirect_pc);
                halted     = is_mis(redirect_pc);
                exp_mis    = halted;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        first_acc = -1;
        first_val = -1;
    endtask

    task automatic redirect(input logic [31:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        tick();
    endtask

    initial begin
        int n0;
        int p0;
        logic [31:0] a0;

        // reset state
        lat = 1;
        do_reset();
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", fetch_misalign, 1'b0);

        // sequential stream, latency and throughput
        tick();
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        ticks(6);
        chk("latency", first_val - first_acc, 32'd2);
        n0 = n_pop;
        ticks(8);
        chk("throughput", n_pop - n0, 32'd8);

        // backpressure fills the buffer, then drains in order
        do_reset();
        instr_ready = 1'b0;
        n0 = n_acc;
        ticks(12);
        chk("full_accepts", n_acc - n0, DEPTH);
        chk("full_req_valid", imem_req_valid, 1'b0);
        chk("full_instr_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        p0 = n_pop;
        n0 = n_acc;
        ticks(12);
        chk("drain", (n_pop - p0) >= 8, 1'b1);
        chk("resume", (n_acc - n0) > 0, 1'b1);

        // redirect with three requests in flight
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && mq.size() != 3; i++)
            tick();
        chk("t3_inflight", mq.size(), 32'd3);
        redirect(32'h0000_0100);
        chk("flush_empty", instr_valid, 1'b0);
        p0 = n_pop;
        ticks(14);
        chk("post_redirect", (n_pop - p0) > 0, 1'b1);

        // request held while memory stalls
        lat = 1;
        imem_req_ready = 1'b0;
        ticks(4);
        a0 = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", imem_req_valid, 1'b1);
            chk("stall_addr", imem_req_addr, a0);
        end
        imem_req_ready = 1'b1;
        ticks(6);

        // PC wraps through zero
        saw_zero = 1'b0;
        redirect(32'hFFFF_FFF0);
        ticks(15);
        chk("wrap", saw_zero, 1'b1);

        // misaligned redirect target
        redirect(32'h0000_0102);
`ifdef IFU_ALIGN_CHECK_EN
        chk("halt_flag", fetch_misalign, 1'b1);
        ticks(6);
        redirect(32'h0000_0200);
        chk("halt_clear", fetch_misalign, 1'b0);
`endif
        p0 = n_pop;
        ticks(10);
        chk("after_misalign", (n_pop - p0) > 0, 1'b1);

        // randomized traffic
        p0 = n_pop;
        for (int i = 0; i < 3000; i++) begin
            int r;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 3);
            rst_n          = ($urandom_range(0, 299) != 0);
            if (rst_n && $urandom_range(0, 29) == 0) begin
                r = $urandom_range(0, 3);
                redirect_valid = 1'b1;
                case (r)
                    0: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                    1: redirect_pc = $urandom | 32'h1;
                    default: redirect_pc = $urandom & ~32'h3;
                endcase
            end
            tick();
        end
        rst_n = 1'b1;
        chk("random_progress", (n_pop - p0) > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
